mac_requant_out: RTL and testbench

Output stage directly downstream of the saturating MAC. It watches the MAC's 28-bit accumulator stream, captures the final accumulation of each dot product (every VEC_LEN-th valid sample), then optionally applies ReLU, rescales by a rounding arithmetic right shift and saturates to the 14-bit signed activation width. Results are buffered in a small FIFO with a ready/valid handshake to the next layer. The MAC cannot stall, so a full FIFO drops the result and flags the loss.

---
 rtl/mac_pkg.sv | 39 +++
 rtl/mac_requant_out_if.sv | 20 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/mac_requant_out.sv | 87 ++++++++
 tb/tb_mac_requant_out.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared MAC-datapath definitions: accumulator/activation widths, the activation
// word format and the requantize function used by the output stage and its benches.
package mac_pkg;

    localparam int ACC_W = 28;
    localparam int ACT_W = 14;

    typedef struct packed {
        logic                    sat;
        logic signed [ACT_W-1:0] data;
    } act_word_t;

    localparam logic signed [ACC_W:0] ACT_MAX = (ACC_W+1)'(2**(ACT_W-1) - 1);
    localparam logic signed [ACC_W:0] ACT_MIN = (ACC_W+1)'(-(2**(ACT_W-1)));

    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic act_word_t requant(input logic signed [ACC_W-1:0] x,
                                          input logic relu_en,
                                          input int shift = 10);
        logic signed [ACC_W:0] r;
        logic signed [ACC_W:0] half;
        logic signed [ACC_W:0] s;
        act_word_t w;
        r = (relu_en && x[ACC_W-1]) ? '0 : {x[ACC_W-1], x};
        half = (ACC_W+1)'(1) <<< (shift - 1);
        s = (r + half) >>> shift;
        w.sat = 1'b1;
        if (s > ACT_MAX) begin
            w.data = ACT_MAX[ACT_W-1:0];
        end else if (s < ACT_MIN) begin
            w.data = ACT_MIN[ACT_W-1:0];
        end else begin
            w.sat  = 1'b0;
            w.data = s[ACT_W-1:0];
        end
        return w;
    endfunction

endpackage

// File: rtl/mac_requant_out_if.sv
// Stream interface of the requantizing output stage: MAC accumulator in,
// ready/valid activation stream out.
interface mac_requant_out_if
    import mac_pkg::*;
#(
    parameter int IN_W  = ACC_W,
    parameter int OUT_W = ACT_W
);
    logic signed [IN_W-1:0]  in_data;
    logic                    in_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;
    logic                    out_valid;
    logic                    out_ready;

    modport master (output in_data, in_valid, out_ready,
                    input  out_data, out_sat, out_valid);
    modport slave  (input  in_data, in_valid, out_ready,
                    output out_data, out_sat, out_valid);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/mac_requant_out.sv
// MAC output stage: captures every VEC_LEN-th accumulator sample, requantizes it
// and queues the result for the next layer, flagging results lost to a full FIFO.
module mac_requant_out
    import mac_pkg::*;
#(
    parameter int IN_W    = ACC_W,
    parameter int OUT_W   = ACT_W,
    parameter int VEC_LEN = 8,
    parameter int SHIFT   = 10,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    mac_requant_out_if.slave       bus,
    input  logic                   clr,
    input  logic                   relu_en,
    output logic                   drop_err,
    output logic [$clog2(DEPTH):0] level
);
    localparam int              CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

    logic [CNT_W-1:0]       cnt;
    logic signed [IN_W-1:0] sample;
    logic                   capture;
    logic                   s1_valid;
    act_word_t              s1_word;
    act_word_t              head;
    logic                   full;
    logic                   empty;
    logic                   pop;

    assign sample  = bus.in_data;
    assign capture = bus.in_valid && !clr && (cnt == LAST);
    assign pop     = bus.out_ready && !empty;

    // clr wins over a simultaneous sample, which is then neither counted nor captured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (bus.in_valid) begin
            cnt <= capture ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
        end else begin
            s1_valid <= capture;
            if (capture) begin
                s1_word <= requant(ACC_W'(sample), relu_en, SHIFT);
            end
        end
    end

    // The MAC cannot stall, so an unaccepted stage-1 result is lost for good.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_err <= 1'b0;
        end else if (s1_valid && full && !pop) begin
            drop_err <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH($bits(act_word_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s1_valid),
        .pop   (pop),
        .din   (s1_word),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign bus.out_valid = !empty;
    assign bus.out_data  = OUT_W'(head.data);
    assign bus.out_sat   = head.sat;
endmodule

// File: tb/tb_mac_requant_out.sv
// Bench for mac_requant_out: vector table, counter/backpressure/reset sequences
// and a randomized run against an arithmetic reference model.
module tb_mac_requant_out;

    typedef struct {
        longint x;
        bit     relu;
        longint data;
        bit     sat;
    } vec_t;

    typedef struct {
        longint data;
        bit     sat;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       clr1, clr8, relu1, relu8;
    logic       drop1, drop8;
    logic [2:0] level1, level8;

    int checks = 0;
    int errors = 0;
    longint got[$];

    mac_requant_out_if #(.IN_W(28), .OUT_W(14)) if1 ();
    mac_requant_out_if #(.IN_W(28), .OUT_W(14)) if8 ();

    mac_requant_out #(.IN_W(28), .OUT_W(14), .VEC_LEN(1), .SHIFT(10), .DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .bus(if1), .clr(clr1), .relu_en(relu1),
        .drop_err(drop1), .level(level1));

    mac_requant_out #(.IN_W(28), .OUT_W(14), .VEC_LEN(8), .SHIFT(10), .DEPTH(4)) dut8 (
        .clk(clk), .reset(reset), .bus(if8), .clr(clr8), .relu_en(relu8),
        .drop_err(drop8), .level(level8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input bit sel8, input longint x, input bit valid,
                                  input bit clr, input bit relu, input bit ready);
        if (sel8) begin
            if8.in_data = 28'(x); if8.in_valid = valid; clr8 = clr; relu8 = relu; if8.out_ready = ready;
        end else begin
            if1.in_data = 28'(x); if1.in_valid = valid; clr1 = clr; relu1 = relu; if1.out_ready = ready;
        end
    endtask

    task automatic tick_collect8();
        tick();
        if (if8.out_valid && if8.out_ready) got.push_back(longint'(if8.out_data));
    endtask

    task automatic do_reset();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_valid1"}, if1.out_valid, 0);
        check_output({tag, "_data1"},  if1.out_data, 0);
        check_output({tag, "_sat1"},   if1.out_sat, 0);
        check_output({tag, "_drop1"},  drop1, 0);
        check_output({tag, "_level1"}, level1, 0);
        check_output({tag, "_valid8"}, if8.out_valid, 0);
        check_output({tag, "_drop8"},  drop8, 0);
        check_output({tag, "_level8"}, level8, 0);
    endtask

    // Reference: round-half-up division by 1024, then clamp to 14-bit signed.
    function automatic exp_t model_requant(input longint x, input bit relu);
        longint r, n, s;
        exp_t e;
        r = (relu && x < 0) ? 0 : x;
        n = r + 512;
        s = (n >= 0) ? n / 1024 : -((-n + 1023) / 1024);
        e.sat = 1'b0;
        if (s > 8191) begin
            s = 8191; e.sat = 1'b1;
        end else if (s < -8192) begin
            s = -8192; e.sat = 1'b1;
        end
        e.data = s;
        return e;
    endfunction

    initial begin
        vec_t vecs[9];
        exp_t fifo_q[$];
        exp_t s1_val;
        bit   s1_live;
        bit   model_drop;

        vecs[0] = '{1536, 0, 2, 0};
        vecs[1] = '{-1536, 0, -1, 0};
        vecs[2] = '{511, 0, 0, 0};
        vecs[3] = '{512, 0, 1, 0};
        vecs[4] = '{134217727, 0, 8191, 1};
        vecs[5] = '{-134217728, 0, -8192, 1};
        vecs[6] = '{8191 * 1024, 0, 8191, 0};
        vecs[7] = '{-5000, 1, 0, 0};
        vecs[8] = '{-5000, 0, -5, 0};

        apply_stimulus(0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(0, vecs[i].x, 1, 0, vecs[i].relu, 1);
            tick();
            apply_stimulus(0, 0, 0, 0, vecs[i].relu, 1);
            check_output($sformatf("vec%0d_lat1", i), if1.out_valid, 0);
            tick();
            check_output($sformatf("vec%0d_valid", i), if1.out_valid, 1);
            check_output($sformatf("vec%0d_data", i), if1.out_data, vecs[i].data);
            check_output($sformatf("vec%0d_sat", i), if1.out_sat, vecs[i].sat);
            tick();
            check_output($sformatf("vec%0d_popped", i), if1.out_valid, 0);
        end

        got.delete();
        for (int k = 1; k <= 16; k++) begin
            apply_stimulus(1, 1024 * k, 1, 0, 0, 1);
            tick_collect8();
            if (k == 4) begin
                apply_stimulus(1, 0, 0, 0, 0, 1);
                tick_collect8();
                tick_collect8();
            end
        end
        apply_stimulus(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) tick_collect8();
        check_output("cnt_count", got.size(), 2);
        if (got.size() == 2) begin
            check_output("cnt_first", got[0], 8);
            check_output("cnt_second", got[1], 16);
        end

        got.delete();
        for (int k = 1; k <= 3; k++) begin
            apply_stimulus(1, 1024 * k, 1, 0, 0, 1);
            tick_collect8();
        end
        apply_stimulus(1, 1024 * 99, 1, 1, 0, 1);
        tick_collect8();
        for (int k = 4; k <= 11; k++) begin
            apply_stimulus(1, 1024 * k, 1, 0, 0, 1);
            tick_collect8();
        end
        apply_stimulus(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) tick_collect8();
        check_output("clr_count", got.size(), 1);
        if (got.size() == 1) check_output("clr_value", got[0], 11);

        do_reset();
        fifo_q.delete();
        s1_live = 0;
        model_drop = 0;
        tick();
        for (int cyc = 0; cyc < 500; cyc++) begin
            logic signed [27:0] xr;
            bit v, c, rl, rd, pop;
            check_output("rand_valid", if1.out_valid, (fifo_q.size() > 0) ? 1 : 0);
            check_output("rand_level", level1, fifo_q.size());
            check_output("rand_drop", drop1, model_drop);
            if (fifo_q.size() > 0) begin
                check_output("rand_data", if1.out_data, fifo_q[0].data);
                check_output("rand_sat", if1.out_sat, fifo_q[0].sat);
            end
            case ($urandom_range(0, 3))
                0: xr = 28'($urandom);
                1: xr = 28'($urandom_range(0, 40000)) - 28'd20000;
                2: xr = 28'($urandom_range(0, 20000000)) - 28'd10000000;
                default: xr = ($urandom_range(0, 1) == 1) ? 28'h7FF_FFFF : 28'h800_0000;
            endcase
            v  = ($urandom_range(0, 9) < 7);
            c  = ($urandom_range(0, 19) == 0);
            rl = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 9) < 5);
            apply_stimulus(0, longint'(xr), v, c, rl, rd);
            pop = (fifo_q.size() > 0) && rd;
            if (pop) void'(fifo_q.pop_front());
            if (s1_live) begin
                if (fifo_q.size() < 4) fifo_q.push_back(s1_val);
                else model_drop = 1;
            end
            s1_live = v && !c;
            if (s1_live) s1_val = model_requant(longint'(xr), rl);
            tick();
        end

        do_reset();
        for (int k = 1; k <= 5; k++) begin
            apply_stimulus(0, 1024 * k, 1, 0, 0, 0);
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0);
        tick();
        check_output("bp_level", level1, 4);
        check_output("bp_drop", drop1, 1);
        check_output("bp_valid", if1.out_valid, 1);
        apply_stimulus(0, 0, 0, 0, 0, 1);
        for (int j = 1; j <= 4; j++) begin
            check_output($sformatf("bp_drain%0d", j), if1.out_data, j);
            tick();
        end
        check_output("bp_empty_valid", if1.out_valid, 0);
        check_output("bp_empty_level", level1, 0);

        apply_stimulus(0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            apply_stimulus(0, 1024 * k, 1, 0, 0, 0);
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("rst_pre_level", level1, 3);
        reset = 1'b0;
        #1;
        check_idle("rst_mid");
        tick();
        reset = 1'b1;
        tick();
        check_output("rst_s1_cleared", level1, 0);
        apply_stimulus(0, 3072, 1, 0, 0, 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 1);
        check_output("rst_lat1", if1.out_valid, 0);
        tick();
        check_output("rst_lat2", if1.out_valid, 1);
        check_output("rst_data", if1.out_data, 3);
        tick();

        do_reset();
        for (int k = 1; k <= 5; k++) begin
            apply_stimulus(0, 1024 * k, 1, 0, 0, 0);
            tick();
        end
        apply_stimulus(0, 0, 0, 0, 0, 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("pp_level", level1, 4);
        check_output("pp_drop", drop1, 0);
        apply_stimulus(0, 0, 0, 0, 0, 1);
        for (int j = 2; j <= 5; j++) begin
            check_output($sformatf("pp_drain%0d", j), if1.out_data, j);
            tick();
        end
        check_output("pp_empty", if1.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
